video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Free-running raster timing generator for the GPU, directly upstream of the pixel fetch stage.
- Divides the system clock into a pixel strobe.
- Produces the horizontal/vertical position counters (cycle, scanline) that the pixel stage consumes.
- Generates sync, blanking and visible-area flags, a frame-start pulse, a frame counter and a CPU-facing vblank interrupt with acknowledge.

Parameters:
CLK_DIV, 4, system clocks per pixel; pixel stage needs 4 fetch steps per pixel.
H_VISIBLE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch (pixels).
H_SYNC, 96, horizontal sync width (pixels).
H_BACK, 48, horizontal back porch (pixels).
V_VISIBLE, 480, visible lines.
V_FRONT, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BACK, 33, vertical back porch (lines).
SYNC_ACTIVE, 0, active level of hsync/vsync (0 = negative polarity).

Ports:
clk  in  1  system clock, the only clock in the block.
rst  in  1  asynchronous, active-low reset.
pixel_strobe  out  1  one-clk pulse, once every CLK_DIV clocks.
cycle  out  10  horizontal pixel position, 0..H_TOTAL-1.
scanline  out  9  line position, low 9 bits of the internal line counter; valid while vblank=0.
hsync  out  1  horizontal sync.
vsync  out  1  vertical sync.
hblank  out  1  high when cycle >= H_VISIBLE.
vblank  out  1  high when line >= V_VISIBLE.
visible  out  1  high when hblank=0 and vblank=0.
frame_start  out  1  one-clk pulse when the counters wrap to (0,0).
frame_count  out  8  number of completed frames, modulo 256.
vblank_irq  out  1  sticky interrupt request.
irq_ack  in  1  one-clk acknowledge from the CPU bus; clears vblank_irq.

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - The internal line counter is 10 bits.
- Reset (async assert, sync release):
  - prescaler=0, cycle=0, line=0, frame_count=0.
  - pixel_strobe=0, frame_start=0, vblank_irq=0.
  - hsync=vsync=!SYNC_ACTIVE, hblank=vblank=0, visible=1.
  - Reset mid-frame discards all position; counting restarts at (0,0).
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_strobe is registered and high for exactly the clk in which prescaler==CLK_DIV-1.
  - The first strobe occurs CLK_DIV clocks after reset release.
- Counters advance only on clocks where pixel_strobe is high:
  - cycle increments; cycle==H_TOTAL-1 wraps to 0 and increments line.
  - line==V_TOTAL-1 together with cycle wrap sets line to 0, increments frame_count (255 wraps to 0) and pulses frame_start for that one clk.
- Flag registers are decoded from the next counter values, so they change on the same clk edge as cycle/scanline (zero relative latency):
  - hsync = SYNC_ACTIVE while H_VISIBLE+H_FRONT <= cycle < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync = SYNC_ACTIVE while line is 490..491 (same form on the V parameters).
- vblank_irq:
  - Set on the strobe where line becomes V_VISIBLE at cycle 0.
  - Cleared by irq_ack. If set and ack occur in the same clk, set wins.
  - An ack while vblank_irq=0 has no effect.
  - The request remains held across frames until acknowledged.
- scanline is undefined as content during vblank; the pixel stage must gate on visible.

Optional Feature:
TIMING_SYNC_DELAY_EN
- Defined: hsync, vsync, hblank, vblank and visible each pass through one extra register stage, loaded on pixel_strobe. They lag cycle/scanline by exactly one pixel period, aligning them with the pixel stage's one-pixel fetch latency. The delay stage resets to hsync=vsync=!SYNC_ACTIVE, hblank=vblank=visible=0.
- Undefined: the flags are zero-latency as described in Behaviour.
- cycle, scanline, frame_start and vblank_irq are unaffected in both cases.

Decomposition:
- Shared package gpu_timing_pkg holds:
  - the timing constants (visible, porch and sync widths);
  - H_TOTAL and V_TOTAL;
  - counter widths (10-bit cycle, 10-bit line, 9-bit scanline);
  - CLK_DIV.
- One natural sub-module, pixel_prescaler: the CLK_DIV counter and pixel_strobe generation, reusable by other GPU stages.

Test Plan:
- Reset release, then count clk edges → first pixel_strobe at clk 4, then every 4 clks; cycle reads 1 after the first strobe.
- Run one line → hsync low exactly for cycle 656..751, hblank high for cycle 640..799, cycle wraps 799→0 and line increments.
- Run one full frame → vsync low for lines 490..491, vblank rises at line 480 cycle 0, frame_start pulses once at the wrap from (799,524) to (0,0), frame_count=1.
- vblank_irq set at line 480 → irq_ack two clks later clears it; irq_ack asserted on the exact set clk → vblank_irq stays 1.
- Run 256 frames → frame_count wraps 255→0 with no glitch on frame_start.
- Assert rst at line 300, cycle 400 → all outputs return to reset values asynchronously; after release, timing restarts from (0,0). With TIMING_SYNC_DELAY_EN defined, hsync falls one strobe after cycle reaches 656.

Source files
------------

// File: rtl/gpu_timing_pkg.sv
// Raster timing constants shared by the GPU display stages (640x480 @ 4 clks/pixel).
package gpu_timing_pkg;
   localparam int CLK_DIV = 4;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int CYCLE_W    = 10;
   localparam int LINE_W     = 10;
   localparam int SCANLINE_W = 9;

   localparam logic SYNC_ACTIVE = 1'b0;

   // Half-open window test used for the sync pulses.
   function automatic logic in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction
endpackage

// File: rtl/pixel_prescaler.sv
// Divides the system clock into a registered one-clk pixel strobe, every DIV clocks.
module pixel_prescaler
   import gpu_timing_pkg::*;
#(
   parameter int DIV = CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic pixel_strobe
);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count, count_nxt;

   always_comb begin
      count_nxt = (count == LAST) ? '0 : count + 1'b1;
   end

   // Strobe is registered against the next count so it is high exactly while count==LAST.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count        <= '0;
         pixel_strobe <= 1'b0;
      end else begin
         count        <= count_nxt;
         pixel_strobe <= (count_nxt == LAST);
      end
   end
endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: position counters, sync/blank flags, frame pulse, vblank IRQ.
// Define TIMING_SYNC_DELAY_EN to delay the sync/blank/visible flags by one pixel period.
module video_timing_gen
   import gpu_timing_pkg::*;
#(
   parameter int   CLK_DIV     = gpu_timing_pkg::CLK_DIV,
   parameter int   H_VISIBLE   = gpu_timing_pkg::H_VISIBLE,
   parameter int   H_FRONT     = gpu_timing_pkg::H_FRONT,
   parameter int   H_SYNC      = gpu_timing_pkg::H_SYNC,
   parameter int   H_BACK      = gpu_timing_pkg::H_BACK,
   parameter int   V_VISIBLE   = gpu_timing_pkg::V_VISIBLE,
   parameter int   V_FRONT     = gpu_timing_pkg::V_FRONT,
   parameter int   V_SYNC      = gpu_timing_pkg::V_SYNC,
   parameter int   V_BACK      = gpu_timing_pkg::V_BACK,
   parameter logic SYNC_ACTIVE = gpu_timing_pkg::SYNC_ACTIVE
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  pixel_strobe,
   output logic [CYCLE_W-1:0]    cycle,
   output logic [SCANLINE_W-1:0] scanline,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  hblank,
   output logic                  vblank,
   output logic                  visible,
   output logic                  frame_start,
   output logic [7:0]            frame_count,
   output logic                  vblank_irq,
   input  logic                  irq_ack
);
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [CYCLE_W-1:0] cycle_nxt;
   logic [LINE_W-1:0]  line, line_nxt;
   logic h_wrap, v_last, frame_wrap, irq_set;
   logic hsync_d, vsync_d, hblank_d, vblank_d;
   logic hsync_q, vsync_q, hblank_q, vblank_q, visible_q;

   pixel_prescaler #(.DIV(CLK_DIV)) u_prescaler (
      .clk          (clk),
      .rst          (rst),
      .pixel_strobe (pixel_strobe)
   );

   always_comb begin
      h_wrap     = pixel_strobe && (cycle == CYCLE_W'(H_TOTAL - 1));
      v_last     = (line == LINE_W'(V_TOTAL - 1));
      frame_wrap = h_wrap && v_last;
      cycle_nxt  = cycle;
      line_nxt   = line;
      if (pixel_strobe) cycle_nxt = h_wrap ? '0 : cycle + 1'b1;
      if (h_wrap)       line_nxt  = v_last ? '0 : line + 1'b1;
      irq_set    = h_wrap && (line_nxt == LINE_W'(V_VISIBLE));
   end

   // Flags decode the next position so they move on the same edge as the counters.
   always_comb begin
      hblank_d = (cycle_nxt >= CYCLE_W'(H_VISIBLE));
      vblank_d = (line_nxt >= LINE_W'(V_VISIBLE));
      hsync_d  = in_range(int'(cycle_nxt), HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d  = in_range(int'(line_nxt), VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle       <= '0;
         line        <= '0;
         frame_count <= '0;
         frame_start <= 1'b0;
         vblank_irq  <= 1'b0;
         hsync_q     <= ~SYNC_ACTIVE;
         vsync_q     <= ~SYNC_ACTIVE;
         hblank_q    <= 1'b0;
         vblank_q    <= 1'b0;
         visible_q   <= 1'b1;
      end else begin
         cycle       <= cycle_nxt;
         line        <= line_nxt;
         frame_start <= frame_wrap;
         if (frame_wrap) frame_count <= frame_count + 1'b1;
         if (irq_set)      vblank_irq <= 1'b1;
         else if (irq_ack) vblank_irq <= 1'b0;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         hblank_q    <= hblank_d;
         vblank_q    <= vblank_d;
         visible_q   <= ~hblank_d & ~vblank_d;
      end
   end

   assign scanline = line[SCANLINE_W-1:0];

`ifdef TIMING_SYNC_DELAY_EN
   // One-pixel lag to line up with the fetch stage's pipeline latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync   <= ~SYNC_ACTIVE;
         vsync   <= ~SYNC_ACTIVE;
         hblank  <= 1'b0;
         vblank  <= 1'b0;
         visible <= 1'b0;
      end else if (pixel_strobe) begin
         hsync   <= hsync_q;
         vsync   <= vsync_q;
         hblank  <= hblank_q;
         vblank  <= vblank_q;
         visible <= visible_q;
      end
   end
`else
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign hblank  = hblank_q;
   assign vblank  = vblank_q;
   assign visible = visible_q;
`endif
endmodule
